// File: rtl/drac_icache_pkg.sv
// Shared configuration, FSM encoding and helpers for the icache data array.
package drac_icache_pkg;

    localparam int unsigned ICACHE_N_WAY = 4;
    localparam int unsigned SET_WIDTH    = 128;
    localparam int unsigned ICACHE_DEPTH = 256;
    localparam int unsigned ADDR_WIDTH   = $clog2(ICACHE_DEPTH);
    localparam int unsigned FILL_WIDTH   = 64;
    localparam int unsigned BEATS        = SET_WIDTH / FILL_WIDTH;
    localparam int unsigned CNT_WIDTH    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } fill_state_t;

    // Refill target captured on beat 0.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [ICACHE_N_WAY-1:0] way;
    } fill_ctx_t;

    // Even parity: one bit per FILL_WIDTH chunk of a line.
    function automatic logic [BEATS-1:0] chunk_parity(input logic [SET_WIDTH-1:0] line);
        logic [BEATS-1:0] p;
        p = '0;
        for (int b = 0; b < BEATS; b++) begin
            p[b] = ^line[b*FILL_WIDTH +: FILL_WIDTH];
        end
        return p;
    endfunction

endpackage

// File: rtl/icache_way_bank.sv
// One cache way: DEPTH x SET_WIDTH 1R/1W synchronous SRAM model with registered read data.
// Optional per-chunk parity storage and check when ICACHE_PARITY_EN is defined.
module icache_way_bank
    import drac_icache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [SET_WIDTH-1:0]  wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [SET_WIDTH-1:0]  rd_data_o
`ifdef ICACHE_PARITY_EN
    ,
    output logic                  parity_err_o
`endif
);

    logic [SET_WIDTH-1:0] mem_q [ICACHE_DEPTH];
    logic [SET_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

`ifdef ICACHE_PARITY_EN
    logic [BEATS-1:0] par_q [ICACHE_DEPTH];
    logic             err_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            par_q[wr_addr_i] <= chunk_parity(wr_data_i);
        end
    end

    // Check is folded into the read register so the flag lines up with the data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (rd_en_i) begin
            err_q <= (chunk_parity(mem_q[rd_addr_i]) != par_q[rd_addr_i]);
        end
    end

    assign parity_err_o = err_q;
`endif

endmodule

// File: rtl/icache_data_array.sv
// N-way icache data array: refill FSM with beat assembly, banked storage, 1-cycle read, hit mux.
// Define ICACHE_PARITY_EN to add per-chunk parity storage and the parity_err_o port.
module icache_data_array
    import drac_icache_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              rd_valid_i,
    output logic                              rd_ready_o,
    input  logic [ADDR_WIDTH-1:0]             rd_addr_i,
    output logic                              rd_valid_o,
    output logic [ICACHE_N_WAY*SET_WIDTH-1:0] data_way_o,
    input  logic [ICACHE_N_WAY-1:0]           hit_way_i,
    output logic [SET_WIDTH-1:0]              data_hit_o,
    input  logic                              fill_valid_i,
    output logic                              fill_ready_o,
    input  logic [FILL_WIDTH-1:0]             fill_data_i,
    input  logic [ADDR_WIDTH-1:0]             fill_addr_i,
    input  logic [ICACHE_N_WAY-1:0]           fill_way_i,
    output logic                              fill_done_o
`ifdef ICACHE_PARITY_EN
    ,
    output logic [ICACHE_N_WAY-1:0]           parity_err_o
`endif
);

    fill_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SET_WIDTH-1:0] line_q, line_d;
    fill_ctx_t            ctx_q, ctx_d;
    logic                 ready_q;
    logic                 done_q;
    logic                 rd_valid_q;
    logic                 beat_acc;
    logic                 rd_acc;
    logic                 wr_en;
    logic [ICACHE_N_WAY*SET_WIDTH-1:0] data_way;
    logic [SET_WIDTH-1:0] data_hit_c;

    // Read and refill share one ready: both stall only in the WRITE cycle.
    assign beat_acc = fill_valid_i & ready_q;
    assign rd_acc   = rd_valid_i & ready_q;
    assign wr_en    = (state_q == WRITE) & ~rst_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        ctx_d   = ctx_q;
        case (state_q)
            IDLE, FILL: begin
                if (beat_acc) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_WIDTH'(b)) begin
                            line_d[b*FILL_WIDTH +: FILL_WIDTH] = fill_data_i;
                        end
                    end
                    if (cnt_q == '0) begin
                        ctx_d.addr = fill_addr_i;
                        ctx_d.way  = fill_way_i;
                    end
                    if (cnt_q == CNT_WIDTH'(BEATS - 1)) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        state_d = FILL;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= (state_d != WRITE);
            done_q     <= (state_d == WRITE);
            rd_valid_q <= rd_acc;
        end
    end

    // Line buffer and target are don't-care until beat 0 loads them.
    always_ff @(posedge clk_i) begin
        line_q <= line_d;
        ctx_q  <= ctx_d;
    end

    for (genvar i = 0; i < ICACHE_N_WAY; i++) begin : g_way
        icache_way_bank u_bank (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .wr_en_i      (wr_en & ctx_q.way[i]),
            .wr_addr_i    (ctx_q.addr),
            .wr_data_i    (line_q),
            .rd_en_i      (rd_acc),
            .rd_addr_i    (rd_addr_i),
            .rd_data_o    (data_way[i*SET_WIDTH +: SET_WIDTH])
`ifdef ICACHE_PARITY_EN
            ,
            .parity_err_o (parity_err_o[i])
`endif
        );
    end

    always_comb begin
        data_hit_c = '0;
        for (int i = 0; i < ICACHE_N_WAY; i++) begin
            if (hit_way_i[i]) begin
                data_hit_c = data_hit_c | data_way[i*SET_WIDTH +: SET_WIDTH];
            end
        end
    end

    assign rd_ready_o   = ready_q;
    assign fill_ready_o = ready_q;
    assign fill_done_o  = done_q;
    assign rd_valid_o   = rd_valid_q;
    assign data_way_o   = data_way;
    assign data_hit_o   = data_hit_c;

endmodule

// File: tb/tb_icache_data_array.sv
// Self-checking bench for icache_data_array: vector table plus scoreboarded read model.
module tb_icache_data_array;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         rd_valid_i;
    logic         rd_ready_o;
    logic [7:0]   rd_addr_i;
    logic         rd_valid_o;
    logic [511:0] data_way_o;
    logic [3:0]   hit_way_i;
    logic [127:0] data_hit_o;
    logic         fill_valid_i;
    logic         fill_ready_o;
    logic [63:0]  fill_data_i;
    logic [7:0]   fill_addr_i;
    logic [3:0]   fill_way_i;
    logic         fill_done_o;
`ifdef ICACHE_PARITY_EN
    logic [3:0]   parity_err_o;
`endif

    always #5 clk = ~clk;

    icache_data_array dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rd_valid_i   (rd_valid_i),
        .rd_ready_o   (rd_ready_o),
        .rd_addr_i    (rd_addr_i),
        .rd_valid_o   (rd_valid_o),
        .data_way_o   (data_way_o),
        .hit_way_i    (hit_way_i),
        .data_hit_o   (data_hit_o),
        .fill_valid_i (fill_valid_i),
        .fill_ready_o (fill_ready_o),
        .fill_data_i  (fill_data_i),
        .fill_addr_i  (fill_addr_i),
        .fill_way_i   (fill_way_i),
        .fill_done_o  (fill_done_o)
`ifdef ICACHE_PARITY_EN
        ,
        .parity_err_o (parity_err_o)
`endif
    );

    typedef struct {
        logic        rst;
        logic        rdv;
        logic [7:0]  ra;
        logic        fv;
        logic [63:0] fd;
        logic [7:0]  fa;
        logic [3:0]  fw;
        logic [3:0]  hit;
        logic        chk;
        logic        e_rdy;
        logic        e_done;
        logic        e_rv;
    } vec_t;

    typedef struct {
        logic [511:0] data;
        logic [3:0]   known;
    } rd_exp_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [127:0] m_mem   [4][256];
    bit           m_known [4][256];
    int           m_state;
    int           m_cnt;
    logic [127:0] m_line;
    logic [7:0]   m_addr;
    logic [3:0]   m_way;
    logic [511:0] exp_dw;
    logic [3:0]   exp_known;
    rd_exp_t      sb_q[$];

    vec_t tbl[16];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mv(input logic rst, input logic rdv, input logic [7:0] ra,
                                input logic fv, input logic [63:0] fd, input logic [7:0] fa,
                                input logic [3:0] fw, input logic [3:0] hit);
        vec_t v;
        v = '{rst, rdv, ra, fv, fd, fa, fw, hit, 1'b0, 1'b0, 1'b0, 1'b0};
        return v;
    endfunction

    task automatic cyc(input vec_t v);
        logic [511:0] mask;
        logic [127:0] eh;
        bit           ok;
        rd_exp_t      e;
        rst_i        = v.rst;
        rd_valid_i   = v.rdv;
        rd_addr_i    = v.ra;
        fill_valid_i = v.fv;
        fill_data_i  = v.fd;
        fill_addr_i  = v.fa;
        fill_way_i   = v.fw;
        hit_way_i    = v.hit;
        #1;
        if (v.chk) begin
            check("tbl_rd_ready", 512'(rd_ready_o), 512'(v.e_rdy));
            check("tbl_fill_done", 512'(fill_done_o), 512'(v.e_done));
            check("tbl_rd_valid", 512'(rd_valid_o), 512'(v.e_rv));
        end
        check("rd_ready", 512'(rd_ready_o), 512'(m_state != 2));
        check("fill_ready", 512'(fill_ready_o), 512'(m_state != 2));
        check("fill_done", 512'(fill_done_o), 512'(m_state == 2));
        check("rd_valid", 512'(rd_valid_o), 512'(sb_q.size() != 0));
        if (rd_valid_o === 1'b1 && sb_q.size() != 0) begin
            e         = sb_q.pop_front();
            exp_dw    = e.data;
            exp_known = e.known;
        end
        mask = '0;
        for (int i = 0; i < 4; i++) if (exp_known[i]) mask[i*128 +: 128] = {128{1'b1}};
        if (mask != '0) check("data_way", data_way_o & mask, exp_dw & mask);
        ok = 1'b1;
        eh = '0;
        for (int i = 0; i < 4; i++) begin
            if (v.hit[i]) begin
                if (!exp_known[i]) ok = 1'b0;
                eh = eh | exp_dw[i*128 +: 128];
            end
        end
        if (ok) check("data_hit", 512'(data_hit_o), 512'(eh));

        @(posedge clk);
        if (v.rst) begin
            m_state   = 0;
            m_cnt     = 0;
            sb_q.delete();
            exp_dw    = '0;
            exp_known = 4'hF;
        end else if (m_state == 2) begin
            for (int i = 0; i < 4; i++) begin
                if (m_way[i]) begin
                    m_mem[i][m_addr]   = m_line;
                    m_known[i][m_addr] = 1'b1;
                end
            end
            m_state = 0;
        end else begin
            if (v.rdv) begin
                for (int i = 0; i < 4; i++) begin
                    e.data[i*128 +: 128] = m_mem[i][v.ra];
                    e.known[i]           = m_known[i][v.ra];
                end
                sb_q.push_back(e);
            end
            if (v.fv) begin
                if (m_cnt == 0) begin
                    m_addr = v.fa;
                    m_way  = v.fw;
                end
                m_line[m_cnt*64 +: 64] = v.fd;
                if (m_cnt == 1) begin
                    m_state = 2;
                    m_cnt   = 0;
                end else begin
                    m_state = 1;
                    m_cnt   = 1;
                end
            end
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lost;
        vec_t v;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 256; j++) begin
            m_mem[i][j]   = '0;
            m_known[i][j] = 1'b0;
        end
        rst_i = 1'b1; rd_valid_i = 1'b0; rd_addr_i = '0; hit_way_i = '0;
        fill_valid_i = 1'b0; fill_data_i = '0; fill_addr_i = '0; fill_way_i = '0;
        repeat (2) @(posedge clk);
        #1;
        m_state = 0; m_cnt = 0; m_line = '0; m_addr = '0; m_way = '0;
        exp_dw = '0; exp_known = 4'hF;

        //           rst   rdv   ra     fv    fd      fa     fw       hit      chk rdy done rv
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 64'hC, 8'h12, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 64'hD, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 64'hA, 8'h12, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 64'hB, 8'h55, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h12, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h12, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 64'hE, 8'h12, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 64'hF, 8'h12, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h12, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 8'h12, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 16; k++) begin
            cyc(tbl[k]);
            if (k == 8) check("hit_line_12", 512'(data_hit_o), 512'({64'hB, 64'hA}));
            if (k == 13) check("way3_unchanged", 512'(data_hit_o), 512'({64'hD, 64'hC}));
        end

        // Read held every cycle across two back-to-back fills of 0x30
        lost = 0;
        for (int k = 0; k < 12; k++) begin
            v = mv(1'b0, 1'b1, 8'h30, 1'b0, 64'h0, 8'h30, 4'b0000, 4'b0001);
            if (k == 1) begin v.fv = 1'b1; v.fd = 64'h11; v.fw = 4'b1111; end
            if (k == 2) begin v.fv = 1'b1; v.fd = 64'h22; end
            if (k == 5) begin v.fv = 1'b1; v.fd = 64'h33; v.fw = 4'b0001; end
            if (k == 6) begin v.fv = 1'b1; v.fd = 64'h44; end
            rst_i = 1'b0;
            #1;
            if (rd_ready_o !== 1'b1) lost++;
            #(-0);
            cyc(v);
        end
        check("lost_accepts", 512'(lost), 512'(2));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0001));
        check("fill30_way0", 512'(data_hit_o), 512'({64'h44, 64'h33}));

        // Reset after beat 0 discards the partial line
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b1, 64'h55, 8'h20, 4'b1111, 4'b0000));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b1, 64'h66, 8'h20, 4'b1111, 4'b0000));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b1, 64'h77, 8'h20, 4'b1111, 4'b0000));
        cyc(mv(1'b1, 1'b0, 8'h00, 1'b1, 64'h88, 8'h20, 4'b1111, 4'b0000));
        check("after_rst_data_way", data_way_o, 512'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(mv(1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000));
        end
        cyc(mv(1'b0, 1'b1, 8'h20, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0100));
        check("prefill_20", 512'(data_hit_o), 512'({64'h66, 64'h55}));
        // FSM restarts cleanly
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b1, 64'h99, 8'h21, 4'b0010, 4'b0000));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b1, 64'hAA, 8'h21, 4'b0010, 4'b0000));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000));
        cyc(mv(1'b0, 1'b1, 8'h21, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0010));
        check("refill_21", 512'(data_hit_o), 512'({64'hAA, 64'h99}));

`ifdef ICACHE_PARITY_EN
        dut.g_way[1].u_bank.mem_q[8'h12][5] = ~dut.g_way[1].u_bank.mem_q[8'h12][5];
        m_mem[1][8'h12][5] = ~m_mem[1][8'h12][5];
        cyc(mv(1'b0, 1'b1, 8'h12, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000));
        rst_i = 1'b0; rd_valid_i = 1'b0; #1;
        check("parity_err", 512'(parity_err_o), 512'(4'b0010));
        cyc(mv(1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 8'h00, 4'b0000, 4'b0000));
`endif

        check("scoreboard_empty", 512'(sb_q.size()), 512'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
